serial_sub_ctrl: RTL and testbench



---
 rtl/serial_sub_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_sub_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial WIDTH-bit subtractor controller.
// It runs a one-bit full-subtractor slice (two half_sub cells plus a borrow
// OR) over WIDTH cycles, LSB first. The result is diff = a - b (mod 2^WIDTH)
// and brow = (a < b).
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   start - request pulse, accepted only in IDLE or DONE
//   a, b  - minuend / subtrahend, captured on the accepted start edge
//   busy  - high while the slice is iterating (RUN)
//   done  - single-cycle pulse; diff/brow are valid from this cycle on
//   diff  - last completed result, held until the next completion
//   brow  - final borrow of the last completed result

module half_sub (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bo
);
    assign d  = a ^ b;
    assign bo = ~a & b;
endmodule

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             brow
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [CW-1:0]    cnt;
    logic             bin;
    logic             d0, b0, dbit, b1, bout;
    logic             last;

    // Full-subtractor slice on the current LSBs and the stored borrow.
    half_sub u_hs0 (.a(op_a[0]), .b(op_b[0]), .d(d0),   .bo(b0));
    half_sub u_hs1 (.a(d0),      .b(bin),     .d(dbit), .bo(b1));
    assign bout = b0 | b1;

    // New bit enters at the MSB, so after WIDTH shifts bit 0 sits in acc[0].
    generate
        if (WIDTH == 1) begin : g_acc1
            assign acc_nxt = dbit;
        end else begin : g_accn
            assign acc_nxt = {dbit, acc[WIDTH-1:1]};
        end
    endgenerate

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            brow  <= 1'b0;
            bin   <= 1'b0;
            cnt   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        bin   <= 1'b0;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    acc  <= acc_nxt;
                    bin  <= bout;
                    op_a <= op_a >> 1;
                    op_b <= op_b >> 1;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        // Result includes this cycle's bit and borrow.
                        diff  <= acc_nxt;
                        brow  <= bout;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: a WIDTH=8 and a WIDTH=1 instance.
// Expected results are pushed to a scoreboard queue when a start is driven
// and popped/compared by a monitor when done pulses.
module tb_serial_sub_ctrl;
    typedef struct {
        logic [7:0] d;
        logic       br;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0, start1 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy8, done8, brow8, busy1, done1, brow1;
    logic [7:0] diff8;
    logic [0:0] diff1;

    int   checks = 0, errors = 0, cyc = 0, ndone8 = 0;
    exp_t q8[$];
    exp_t q1[$];

    serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .brow(brow8));

    serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .brow(brow1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle start on the 8-bit DUT; push the expected result.
    task automatic go8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        exp_t e;
        r = {1'b0, a} - {1'b0, b};
        e.d = r[7:0]; e.br = r[8]; e.cyc = cyc + 9;
        a8 = a; b8 = b; start8 = 1'b1;
        q8.push_back(e);
        tick();
        start8 = 1'b0;
    endtask

    task automatic go1(input logic a, input logic b);
        logic [1:0] r;
        exp_t e;
        r = {1'b0, a} - {1'b0, b};
        e.d = {7'b0, r[0]}; e.br = r[1]; e.cyc = cyc + 2;
        a1 = a; b1 = b; start1 = 1'b1;
        q1.push_back(e);
        tick();
        start1 = 1'b0;
    endtask

    task automatic drain(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (q8.size() == 0 && q1.size() == 0) break;
            tick();
        end
        if (i == budget) chk("drain_timeout", q8.size() + q1.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done8) begin
            ndone8++;
            if (q8.size() == 0) chk("d8_spurious_done", 1, 0);
            else begin
                e = q8.pop_front();
                chk("d8_diff", diff8, e.d);
                chk("d8_brow", brow8, e.br);
                chk("d8_latency", cyc, e.cyc);
            end
        end
        if (!rst && done1) begin
            if (q1.size() == 0) chk("d1_spurious_done", 1, 0);
            else begin
                e = q1.pop_front();
                chk("d1_diff", diff1, e.d[0]);
                chk("d1_brow", brow1, e.br);
                chk("d1_latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        int n0;
        int k;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_diff", diff8, 0);
        chk("rst_brow", brow8, 0);
        chk("rst_busy1", busy1, 0);

        // Basic op with busy window check.
        go8(8'h5A, 8'h3C);
        for (int i = 1; i < 8; i++) begin
            chk("busy_window", busy8, 1);
            tick();
        end
        chk("busy_last", busy8, 1);
        tick();
        chk("busy_after", busy8, 0);
        chk("done_at_9", done8, 1);
        drain(20);

        go8(8'h00, 8'h01); drain(20);
        go8(8'h80, 8'h80); drain(20);
        for (int i = 0; i < 4; i++) begin
            go8(8'($urandom), 8'($urandom));
            drain(20);
        end

        // Start during RUN is ignored.
        n0 = ndone8;
        go8(8'h10, 8'h01);
        tick(); tick();
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (12) tick();
        chk("ignored_start_done_cnt", ndone8 - n0, 1);
        chk("ignored_start_diff", diff8, 8'h0F);
        chk("ignored_start_busy", busy8, 0);

        // Reset mid-RUN discards the operation.
        n0 = ndone8;
        go8(8'hAA, 8'h55);
        tick(); tick(); tick();
        rst = 1'b1;
        q8.delete();
        tick();
        rst = 1'b0;
        chk("midrst_busy", busy8, 0);
        chk("midrst_done", done8, 0);
        chk("midrst_diff", diff8, 0);
        chk("midrst_brow", brow8, 0);
        repeat (12) tick();
        chk("midrst_no_done", ndone8 - n0, 0);

        // rst and start together: start dropped.
        a8 = 8'h09; b8 = 8'h01; start8 = 1'b1; rst = 1'b1;
        tick();
        start8 = 1'b0; rst = 1'b0;
        tick();
        chk("rst_start_busy", busy8, 0);

        // Back-to-back: start in the DONE cycle of op1.
        go8(8'h03, 8'h05);
        k = 0;
        while (!done8 && k < 20) begin tick(); k++; end
        chk("b2b_done_seen", done8, 1);
        go8(8'h07, 8'h02);
        chk("b2b_busy_rise", busy8, 1);
        chk("b2b_done_fall", done8, 0);
        for (int i = 0; i < 8; i++) begin
            chk("b2b_diff_hold", diff8, 8'hFE);
            tick();
        end
        drain(20);
        chk("b2b_final_diff", diff8, 8'h05);

        // WIDTH=1 truth table.
        for (int i = 0; i < 4; i++) begin
            go1(i[1], i[0]);
            drain(10);
        end

        repeat (3) tick();
        chk("q_empty_end", q8.size() + q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1);
    end
endmodule
